// File: rtl/batch_arbiter.sv
// Two-requester batch arbiter: round-robin grant, STEPS saturating additions
// per batch into a shared accumulator, FULL lock-out until clr/en/rst.
module batch_arbiter #(
  parameter int unsigned LIMIT_ONE = 30,
  parameter int unsigned LIMIT_ALL = 100,
  parameter int unsigned STEPS     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic [5:0] qty0,
  input  logic [5:0] qty1,
  output logic [1:0] grant,
  output logic       add_en,
  output logic [5:0] add_val,
  output logic [9:0] sum,
  output logic [2:0] step_cnt,
  output logic       done,
  output logic       full,
  output logic       warn,
  output logic       busy
);

  localparam logic [5:0] LIM_ONE = 6'(LIMIT_ONE);
  localparam logic [9:0] LIM_ALL = 10'(LIMIT_ALL);
  localparam logic [2:0] STEPS_W = 3'(STEPS);

  typedef enum logic [1:0] {IDLE, ADD, DONE, FULL} state_t;

  state_t     r_state;
  logic [1:0] r_grant;
  logic [5:0] r_add_val;
  logic [9:0] r_sum;
  logic [2:0] r_step_cnt;
  logic       r_warn;
  logic       r_last_gnt;

  logic       w_pick;
  logic [1:0] w_pick_oh;
  logic [5:0] w_qty;
  logic       w_legal;
  logic [9:0] w_sum_add;

  // Round-robin pick and legality of the picked quantity
  always_comb begin
    w_pick = 1'b0;
    case (req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = ~r_last_gnt;
      default: w_pick = 1'b0;
    endcase
    w_pick_oh = w_pick ? 2'b10 : 2'b01;
    w_qty     = w_pick ? qty1 : qty0;
    w_legal   = (w_qty != 6'd0) && (w_qty <= LIM_ONE);
    // 10-bit sum of values <= LIMIT_ALL and < 64 cannot wrap
    w_sum_add = r_sum + {4'b0000, r_add_val};
  end

  // Controller FSM; clr outranks en, en outranks normal operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_add_val  <= '0;
      r_sum      <= '0;
      r_step_cnt <= '0;
      r_warn     <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      r_warn <= 1'b0;
      if (clr) begin
        r_state    <= IDLE;
        r_grant    <= '0;
        r_step_cnt <= '0;
        r_sum      <= '0;
      end else if (!en) begin
        r_state    <= IDLE;
        r_grant    <= '0;
        r_step_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (req != 2'b00) begin
              r_last_gnt <= w_pick;
              if (w_legal) begin
                r_grant    <= w_pick_oh;
                r_add_val  <= w_qty;
                r_step_cnt <= '0;
                r_state    <= ADD;
              end else begin
                r_warn <= 1'b1;
              end
            end
          end
          ADD: begin
            if (w_sum_add < LIM_ALL) begin
              r_sum      <= w_sum_add;
              r_step_cnt <= r_step_cnt + 3'd1;
              if (r_step_cnt + 3'd1 == STEPS_W) r_state <= DONE;
            end else begin
              r_sum   <= LIM_ALL;
              r_grant <= '0;
              r_state <= FULL;
            end
          end
          DONE: begin
            r_grant    <= '0;
            r_step_cnt <= '0;
            r_state    <= IDLE;
          end
          FULL: r_state <= FULL;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign grant    = r_grant;
  assign add_val  = r_add_val;
  assign sum      = r_sum;
  assign step_cnt = r_step_cnt;
  assign warn     = r_warn;
  assign add_en   = (r_state == ADD);
  assign done     = (r_state == DONE);
  assign full     = (r_state == FULL);
  assign busy     = (r_state == ADD) || (r_state == DONE);

endmodule

// File: tb/tb_batch_arbiter.sv
// Directed bench for batch_arbiter; inputs driven and outputs sampled 1 ns
// after each rising edge.
module tb_batch_arbiter;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [1:0] req;
  logic [5:0] qty0, qty1;
  logic [1:0] grant;
  logic       add_en;
  logic [5:0] add_val;
  logic [9:0] sum;
  logic [2:0] step_cnt;
  logic       done, full, warn, busy;

  int total = 0;
  int bad   = 0;

  batch_arbiter #(.LIMIT_ONE(30), .LIMIT_ALL(100), .STEPS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
    .qty0(qty0), .qty1(qty1), .grant(grant), .add_en(add_en),
    .add_val(add_val), .sum(sum), .step_cnt(step_cnt), .done(done),
    .full(full), .warn(warn), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; req = 2'b00; qty0 = '0; qty1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] v;
    rst = 1'b1; en = 1'b0; clr = 1'b0; req = 2'b00; qty0 = '0; qty1 = '0;
    #1;
    v = {grant, add_en, add_val, sum, step_cnt, done, full, warn, busy};
    total++;
    if (v !== 26'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", v); end
    do_reset();
    v = {grant, add_en, add_val, sum, step_cnt, done, full, warn, busy};
    total++;
    if (v !== 26'd0) begin bad++; $display("FAIL reset_after_release: got %h want 0", v); end
  endtask

  task automatic test_single();
    logic [1:0] eg; logic ea, ed; logic [9:0] es; logic [2:0] ec;
    do_reset();
    en = 1'b1; req = 2'b01; qty0 = 6'd5;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin req = 2'b00; qty0 = 6'd9; end
      eg = (k <= 5) ? 2'b01 : 2'b00;
      ea = (k <= 4);
      ed = (k == 5);
      es = (k <= 4) ? 10'(5 * (k - 1)) : 10'd20;
      ec = (k <= 5) ? 3'(k - 1) : 3'd0;
      total++;
      if (grant !== eg) begin bad++; $display("FAIL single_grant c%0d: got %b want %b", k, grant, eg); end
      total++;
      if (add_en !== ea) begin bad++; $display("FAIL single_add_en c%0d: got %b want %b", k, add_en, ea); end
      total++;
      if (done !== ed) begin bad++; $display("FAIL single_done c%0d: got %b want %b", k, done, ed); end
      total++;
      if (sum !== es) begin bad++; $display("FAIL single_sum c%0d: got %0d want %0d", k, sum, es); end
      total++;
      if (step_cnt !== ec) begin bad++; $display("FAIL single_step c%0d: got %0d want %0d", k, step_cnt, ec); end
      total++;
      if (add_val !== 6'd5) begin bad++; $display("FAIL single_add_val c%0d: got %0d want 5", k, add_val); end
    end
  endtask

  task automatic test_back_to_back();
    int exp_sum [3] = '{12, 40, 52};
    logic [1:0] exp_gnt [3] = '{2'b01, 2'b10, 2'b01};
    int dcnt = 0;
    do_reset();
    en = 1'b1; req = 2'b11; qty0 = 6'd3; qty1 = 6'd7;
    for (int b = 0; b < 3; b++) begin
      for (int c = 1; c <= 6; c++) begin
        tick();
        if (done === 1'b1) dcnt++;
        if (c == 1) begin
          total++;
          if (grant !== exp_gnt[b]) begin bad++; $display("FAIL b2b_grant b%0d: got %b want %b", b, grant, exp_gnt[b]); end
        end
        if (c == 5) begin
          total++;
          if (done !== 1'b1) begin bad++; $display("FAIL b2b_done b%0d: got %b want 1", b, done); end
          total++;
          if (sum !== 10'(exp_sum[b])) begin bad++; $display("FAIL b2b_sum b%0d: got %0d want %0d", b, sum, exp_sum[b]); end
        end
        if (c == 6) begin
          total++;
          if ({grant, busy} !== 3'b000) begin bad++; $display("FAIL b2b_idle_gap b%0d: got grant=%b busy=%b want 00/0", b, grant, busy); end
          if (b == 2) req = 2'b00;
        end
      end
    end
    total++;
    if (dcnt != 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", dcnt); end
  endtask

  task automatic test_reject();
    do_reset();
    en = 1'b1; req = 2'b10; qty1 = 6'd31;
    tick();
    total++;
    if ({warn, grant, sum} !== {1'b1, 2'b00, 10'd0}) begin bad++; $display("FAIL reject_31: got warn=%b grant=%b sum=%0d want 1/00/0", warn, grant, sum); end
    req = 2'b00;
    tick();
    total++;
    if (warn !== 1'b0) begin bad++; $display("FAIL reject_31_pulse: got warn=%b want 0", warn); end
    req = 2'b10; qty1 = 6'd0;
    tick();
    total++;
    if ({warn, grant, sum} !== {1'b1, 2'b00, 10'd0}) begin bad++; $display("FAIL reject_0: got warn=%b grant=%b sum=%0d want 1/00/0", warn, grant, sum); end
    req = 2'b00;
    tick();
    total++;
    if (warn !== 1'b0) begin bad++; $display("FAIL reject_0_pulse: got warn=%b want 0", warn); end
    // requester 0 rejected on contention, so requester 1 wins the next pick
    req = 2'b11; qty0 = 6'd0; qty1 = 6'd30;
    tick();
    total++;
    if ({warn, grant} !== {1'b1, 2'b00}) begin bad++; $display("FAIL reject_contend: got warn=%b grant=%b want 1/00", warn, grant); end
    tick();
    total++;
    if ({warn, grant, add_val} !== {1'b0, 2'b10, 6'd30}) begin bad++; $display("FAIL accept_limit: got warn=%b grant=%b add_val=%0d want 0/10/30", warn, grant, add_val); end
  endtask

  task automatic test_saturate();
    int dcnt = 0;
    do_reset();
    en = 1'b1; req = 2'b01; qty0 = 6'd30;
    tick();
    req = 2'b00;
    repeat (3) tick();
    total++;
    if ({sum, step_cnt} !== {10'd90, 3'd3}) begin bad++; $display("FAIL sat_setup: got sum=%0d step=%0d want 90/3", sum, step_cnt); end
    en = 1'b0;
    tick();
    en = 1'b1; req = 2'b01; qty0 = 6'd6;
    tick();
    total++;
    if ({grant, add_val, sum} !== {2'b01, 6'd6, 10'd90}) begin bad++; $display("FAIL sat_start: got grant=%b add_val=%0d sum=%0d want 01/6/90", grant, add_val, sum); end
    tick();
    total++;
    if (sum !== 10'd96) begin bad++; $display("FAIL sat_96: got %0d want 96", sum); end
    tick();
    total++;
    if ({sum, full, grant, add_en, done, busy} !== {10'd100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL sat_full: got sum=%0d full=%b grant=%b add_en=%b done=%b busy=%b want 100/1/00/0/0/0", sum, full, grant, add_en, done, busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done === 1'b1) dcnt++;
      total++;
      if ({sum, full, grant, add_en} !== {10'd100, 1'b1, 2'b00, 1'b0}) begin
        bad++; $display("FAIL sat_hold c%0d: got sum=%0d full=%b grant=%b add_en=%b want 100/1/00/0", k, sum, full, grant, add_en);
      end
    end
    total++;
    if (dcnt != 0) begin bad++; $display("FAIL sat_no_done: got %0d want 0", dcnt); end
    clr = 1'b1; req = 2'b00;
    tick();
    clr = 1'b0;
    total++;
    if ({sum, full, grant, busy} !== {10'd0, 1'b0, 2'b00, 1'b0}) begin bad++; $display("FAIL sat_clr: got sum=%0d full=%b grant=%b busy=%b want 0/0/00/0", sum, full, grant, busy); end
  endtask

  task automatic test_en_abort();
    int dcnt = 0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      en = 1'b1; req = 2'b01; qty0 = 6'd5;
      tick();
      req = 2'b00;
      repeat (2) begin tick(); if (done === 1'b1) dcnt++; end
      en = 1'b0;
      tick();
      if (done === 1'b1) dcnt++;
      total++;
      if ({grant, step_cnt, sum, busy} !== {2'b00, 3'd0, 10'(10 * (r + 1)), 1'b0}) begin
        bad++; $display("FAIL en_abort r%0d: got grant=%b step=%0d sum=%0d busy=%b want 00/0/%0d/0", r, grant, step_cnt, sum, busy, 10 * (r + 1));
      end
    end
    total++;
    if (dcnt != 0) begin bad++; $display("FAIL en_abort_no_done: got %0d want 0", dcnt); end
  endtask

  task automatic test_clr_abort();
    en = 1'b1; req = 2'b01; qty0 = 6'd5;
    tick();
    req = 2'b00;
    tick();
    total++;
    if (sum !== 10'd25) begin bad++; $display("FAIL clr_pre: got sum=%0d want 25", sum); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if ({grant, step_cnt, sum, done, busy} !== {2'b00, 3'd0, 10'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clr_abort: got grant=%b step=%0d sum=%0d done=%b busy=%b want 00/0/0/0/0", grant, step_cnt, sum, done, busy);
    end
    tick();
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("FAIL clr_after: got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_async_reset();
    logic [25:0] v;
    do_reset();
    en = 1'b1; req = 2'b01; qty0 = 6'd4;
    tick();
    req = 2'b00;
    tick();
    #3 rst = 1'b1;
    #1;
    v = {grant, add_en, add_val, sum, step_cnt, done, full, warn, busy};
    total++;
    if (v !== 26'd0) begin bad++; $display("FAIL async_reset: got %h want 0", v); end
    #1 rst = 1'b0;
    en = 1'b1; req = 2'b11; qty0 = 6'd4; qty1 = 6'd4;
    tick();
    total++;
    if (grant !== 2'b01) begin bad++; $display("FAIL async_last_gnt: got %b want 01", grant); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reject();
    test_saturate();
    test_en_abort();
    test_clr_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
